// File: rtl/image_frame_writer.sv
// image_frame_writer: captures one raster-order pixel frame into an on-chip buffer with a 1-cycle readback port
// Ports: clk, rst_n (async active-low); start arms one capture from IDLE; pix_in/pix_valid/pix_ready form the
//   stream sink; busy is high while capturing; frame_done pulses one cycle after the final pixel is written;
//   col/row give the position of the next pixel; rd_addr/rd_data read the buffer with read-before-write;
//   checksum (16-bit running sum of accepted pixels) exists only when IMG_CHECKSUM_EN is defined.
module image_frame_writer #(
  parameter int WIDTH = 668,
  parameter int HEIGHT = 452,
  parameter int DATA_W = 8,
  localparam int NPIX = WIDTH * HEIGHT,
  localparam int AW = $clog2(NPIX),
  localparam int CW = $clog2(WIDTH),
  localparam int RW = $clog2(HEIGHT)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DATA_W-1:0] pix_in,
  input  logic              pix_valid,
  output logic              pix_ready,
  output logic              busy,
  output logic              frame_done,
  output logic [CW-1:0]     col,
  output logic [RW-1:0]     row,
  input  logic [AW-1:0]     rd_addr,
`ifdef IMG_CHECKSUM_EN
  output logic [15:0]       checksum,
`endif
  output logic [DATA_W-1:0] rd_data
);
  typedef enum logic [1:0] {IDLE, CAPTURE, DONE} state_e;
  state_e state_q, state_d;
  logic pix_ready_q, pix_ready_d, busy_q, busy_d, frame_done_q, frame_done_d;
  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic [AW-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0] rd_data_q;
  logic [DATA_W-1:0] mem [NPIX];
  logic accept, last, row_end;
  assign accept = pix_valid & pix_ready_q;
  assign last = wr_addr_q == AW'(NPIX - 1);
  assign row_end = col_q == CW'(WIDTH - 1);
  // Counters return to 0 after the final pixel so they never leave the frame.
  always_comb begin
    state_d = state_q;
    col_d = col_q;
    row_d = row_q;
    wr_addr_d = wr_addr_q;
    case (state_q)
      IDLE: if (start) begin
        state_d = CAPTURE;
        col_d = '0;
        row_d = '0;
        wr_addr_d = '0;
      end
      CAPTURE: if (accept) begin
        state_d = last ? DONE : CAPTURE;
        wr_addr_d = last ? '0 : wr_addr_q + AW'(1);
        col_d = (last || row_end) ? '0 : col_q + CW'(1);
        row_d = last ? '0 : row_end ? row_q + RW'(1) : row_q;
      end
      default: state_d = IDLE;
    endcase
    pix_ready_d = state_d == CAPTURE;
    busy_d = state_d == CAPTURE;
    frame_done_d = state_d == DONE;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      pix_ready_q <= 1'b0;
      busy_q <= 1'b0;
      frame_done_q <= 1'b0;
      col_q <= '0;
      row_q <= '0;
      wr_addr_q <= '0;
      rd_data_q <= '0;
    end else begin
      state_q <= state_d;
      pix_ready_q <= pix_ready_d;
      busy_q <= busy_d;
      frame_done_q <= frame_done_d;
      col_q <= col_d;
      row_q <= row_d;
      wr_addr_q <= wr_addr_d;
      rd_data_q <= mem[rd_addr];
    end
  // Buffer contents survive reset; only the write strobe touches them.
  always_ff @(posedge clk)
    if (accept) mem[wr_addr_q] <= pix_in;
`ifdef IMG_CHECKSUM_EN
  logic [15:0] sum_q, sum_d;
  always_comb sum_d = (state_q == IDLE && start) ? '0 : accept ? sum_q + 16'(pix_in) : sum_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) sum_q <= '0;
    else sum_q <= sum_d;
  assign checksum = sum_q;
`endif
  assign pix_ready = pix_ready_q;
  assign busy = busy_q;
  assign frame_done = frame_done_q;
  assign col = col_q;
  assign row = row_q;
  assign rd_data = rd_data_q;
endmodule

// File: tb/tb_image_frame_writer.sv
// tb_image_frame_writer: directed frames checked against a pixel-count model plus literal expectations
module tb_image_frame_writer;
  localparam int W = 4, H = 3, NP = 12, AW = 4, CW = 2, RW = 2;
  logic clk = 0, rst_n = 0, start = 0, pix_valid = 0;
  logic [7:0] pix_in = 0;
  logic [AW-1:0] rd_addr = 0;
  logic pix_ready, busy, frame_done;
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic [7:0] rd_data;
`ifdef IMG_CHECKSUM_EN
  logic [15:0] checksum;
`endif
  int checks = 0, failures = 0, done_pulses = 0;
  logic [7:0] tab [NP];
  always #5 clk = ~clk;
  image_frame_writer #(.WIDTH(W), .HEIGHT(H), .DATA_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .pix_in(pix_in), .pix_valid(pix_valid),
    .pix_ready(pix_ready), .busy(busy), .frame_done(frame_done), .col(col), .row(row),
    .rd_addr(rd_addr),
`ifdef IMG_CHECKSUM_EN
    .checksum(checksum),
`endif
    .rd_data(rd_data));
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask
  // Model: a capture flag, a done flag and the number of pixels taken so far.
  logic [7:0] exp_mem [NP];
  bit exp_known [NP];
  bit m_cap, m_done, m_rd_known;
  int m_k;
  logic [7:0] m_rd;
  logic [15:0] m_sum;
  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      m_cap = 0; m_done = 0; m_k = 0; m_rd = 0; m_rd_known = 1; m_sum = 0;
    end else begin
      m_rd_known = rd_addr < NP && exp_known[rd_addr];
      if (m_rd_known) m_rd = exp_mem[rd_addr];
      if (m_cap) begin
        if (pix_valid) begin
          exp_mem[m_k] = pix_in;
          exp_known[m_k] = 1;
          m_sum = m_sum + 16'(pix_in);
          m_k++;
          if (m_k == NP) begin m_cap = 0; m_done = 1; end
        end
      end else if (m_done) m_done = 0;
      else if (start) begin m_cap = 1; m_k = 0; m_sum = 0; end
    end
  always @(negedge clk)
    if (rst_n) begin
      chk("pix_ready", pix_ready, m_cap);
      chk("busy", busy, m_cap);
      chk("frame_done", frame_done, m_done);
      if (m_cap) begin
        chk("col", col, m_k % W);
        chk("row", row, m_k / W);
      end
      if (m_rd_known) chk("rd_data", rd_data, m_rd);
`ifdef IMG_CHECKSUM_EN
      chk("checksum", checksum, m_sum);
`endif
      if (frame_done) done_pulses++;
    end
  task automatic start_pulse();
    start = 1;
    @(negedge clk);
    start = 0;
  endtask
  task automatic push(input int lo, input int hi);
    for (int i = lo; i < hi; i++) begin
      pix_valid = 1;
      pix_in = tab[i];
      @(negedge clk);
    end
    pix_valid = 0;
  endtask
  task automatic readback(input string name);
    for (int a = 0; a < NP; a++) begin
      rd_addr = AW'(a);
      @(negedge clk);
      chk(name, rd_data, tab[a]);
    end
  endtask
  task automatic chk_reset_outputs(input string name);
    chk({name, "_ready"}, pix_ready, 0);
    chk({name, "_busy"}, busy, 0);
    chk({name, "_done"}, frame_done, 0);
    chk({name, "_col"}, col, 0);
    chk({name, "_row"}, row, 0);
    chk({name, "_rd"}, rd_data, 0);
  endtask
  initial begin
    repeat (2) @(negedge clk);
    chk_reset_outputs("reset");
    rst_n = 1;
    @(negedge clk);
    // single back-to-back frame
    for (int i = 0; i < NP; i++) tab[i] = 8'h10 + 8'(i);
    start_pulse();
    push(0, NP);
    chk("sf_done", frame_done, 1);
    chk("sf_ready", pix_ready, 0);
    @(negedge clk);
    chk("sf_done_clr", frame_done, 0);
    chk("sf_pulses", done_pulses, 1);
    readback("sf_mem");
    // gapped frame: 23 stream cycles, valid on even steps
    for (int i = 0; i < NP; i++) tab[i] = 8'h30 + 8'(i);
    start_pulse();
    for (int s = 0; s < 2 * NP - 1; s++) begin
      pix_valid = s % 2 == 0;
      pix_in = tab[s / 2];
      @(negedge clk);
      if (s == 10) begin chk("gap_col", col, 2); chk("gap_row", row, 1); end
      if (s == 21) chk("gap_early", frame_done, 0);
    end
    pix_valid = 0;
    chk("gap_done", frame_done, 1);
    @(negedge clk);
    readback("gap_mem");
    // pixels with no start are ignored
    pix_valid = 1;
    pix_in = 8'hFF;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("idle_ready", pix_ready, 0);
    end
    pix_valid = 0;
    readback("idle_mem");
    // start inside CAPTURE leaves the counters alone
    for (int i = 0; i < NP; i++) tab[i] = 8'h40 + 8'(i);
    start_pulse();
    push(0, 3);
    start_pulse();
    chk("restart_col", col, 3);
    chk("restart_row", row, 0);
    push(3, NP);
    chk("restart_done", frame_done, 1);
    @(negedge clk);
    // reset in the middle of a frame
    for (int i = 0; i < NP; i++) tab[i] = 8'hA0 + 8'(i);
    start_pulse();
    push(0, 6);
    rst_n = 0;
    #1;
    chk_reset_outputs("abort");
    @(negedge clk);
    chk("abort_done", frame_done, 0);
    rst_n = 1;
    @(negedge clk);
    // read/write collision at address 5 (old 0xA5, new 0x55)
    for (int i = 0; i < NP; i++) tab[i] = 8'(i);
    tab[5] = 8'h55;
    rd_addr = 5;
    start_pulse();
    for (int i = 0; i < NP; i++) begin
      pix_valid = 1;
      pix_in = tab[i];
      @(negedge clk);
      if (i == 5) chk("coll_old", rd_data, 8'hA5);
      if (i == 6) chk("coll_new", rd_data, 8'h55);
    end
    pix_valid = 0;
    chk("coll_done", frame_done, 1);
    @(negedge clk);
    // clean frame 0x00..0x0B after the abort
    for (int i = 0; i < NP; i++) tab[i] = 8'(i);
    start_pulse();
    push(0, NP);
    chk("full_done", frame_done, 1);
    @(negedge clk);
    readback("full_mem");
    // start held high re-arms two cycles after the final accept
    for (int i = 0; i < NP; i++) tab[i] = 8'h60 + 8'(i);
    start = 1;
    @(negedge clk);
    push(0, NP);
    chk("hold_done", frame_done, 1);
    @(negedge clk);
    chk("hold_idle", busy, 0);
    @(negedge clk);
    chk("hold_rearm", busy, 1);
    chk("hold_ready", pix_ready, 1);
    start = 0;
    for (int i = 0; i < NP; i++) tab[i] = 8'hFF;
    push(0, NP);
    chk("ff_done", frame_done, 1);
`ifdef IMG_CHECKSUM_EN
    chk("ff_checksum", checksum, 16'h0BF4);
`endif
    @(negedge clk);
    start_pulse();
    chk("ff_next_busy", busy, 1);
`ifdef IMG_CHECKSUM_EN
    chk("ff_checksum_clr", checksum, 0);
`endif
    push(0, NP);
    @(negedge clk);
    @(negedge clk);
    chk("total_pulses", done_pulses, 8);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
